uart_dbg_cmd_master: RTL and testbench

Command decoder and register-bus initiator for the UART debugger. It consumes bytes from the UART receiver and parses them into write, read and start-test frames. It drives the debugger register interface (`reg_addr`/`reg_wr_en`/`reg_rd_en`/`reg_rd_done`) of the memory-interface block, and streams responses back through the UART transmitter. It runs entirely in the `core_clk_25Mhz` domain.

---
 rtl/uart_dbg_pkg.sv | 23 ++
 rtl/dbg_resp_sender.sv | 53 +++++
 rtl/uart_dbg_cmd_master.sv | 201 ++++++++++++++++++++
 tb/tb_uart_dbg_cmd_master.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_dbg_pkg.sv
// rtl/uart_dbg_pkg.sv - opcode, response and state definitions for the UART debug command master
package uart_dbg_pkg;

    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;
    localparam logic [7:0] OP_START = 8'h53;

    localparam logic [7:0] RSP_OK   = 8'h4B;
    localparam logic [7:0] RSP_ERR  = 8'h3F;
    localparam logic [7:0] RSP_TMO  = 8'h45;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_WR,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_START,
        ST_TX
    } state_e;

endpackage

// File: rtl/dbg_resp_sender.sv
// rtl/dbg_resp_sender.sv - streams a 1..4 byte response MSB first over a valid/ready handshake
module dbg_resp_sender (
    input  logic        core_clk_25Mhz,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic [31:0] bytes_i,
    input  logic [2:0]  count_i,
    input  logic        tx_ready_i,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    output logic        done_o
);

    logic [7:0]  tx_data_q;
    logic        tx_valid_q;
    logic [23:0] rest_q;
    logic [1:0]  left_q;
    logic [2:0]  pad;
    logic [31:0] aligned;
    logic        hs;

    // The payload occupies the low count_i bytes; left-align it so the first byte sits on top.
    assign pad     = 3'd4 - count_i;
    assign aligned = bytes_i << {pad, 3'b000};
    assign hs      = tx_valid_q && tx_ready_i;
    assign done_o  = hs && (left_q == 2'd0);

    assign tx_data_o  = tx_data_q;
    assign tx_valid_o = tx_valid_q;

    always_ff @(posedge core_clk_25Mhz or negedge rst_n) begin
        if (!rst_n) begin
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            rest_q     <= 24'h0;
            left_q     <= 2'd0;
        end else if (load_i) begin
            tx_data_q  <= aligned[31:24];
            rest_q     <= aligned[23:0];
            left_q     <= 2'(count_i - 3'd1);
            tx_valid_q <= 1'b1;
        end else if (hs) begin
            if (left_q == 2'd0) begin
                tx_valid_q <= 1'b0;
            end else begin
                tx_data_q <= rest_q[23:16];
                rest_q    <= {rest_q[15:0], 8'h00};
                left_q    <= left_q - 2'd1;
            end
        end
    end

endmodule

// File: rtl/uart_dbg_cmd_master.sv
// rtl/uart_dbg_cmd_master.sv - parses UART debug frames and drives the debugger register bus
module uart_dbg_cmd_master
    import uart_dbg_pkg::*;
#(
    parameter int unsigned BYTE_TIMEOUT       = 250000,
    parameter int unsigned RD_TIMEOUT         = 16,
    parameter int unsigned START_PULSE_CYCLES = 4
) (
    input  logic        core_clk_25Mhz,
    input  logic        rst_n,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic [7:0]  reg_addr_o,
    output logic [31:0] reg_wr_data_o,
    output logic        reg_wr_en_o,
    output logic        reg_rd_en_o,
    input  logic [31:0] reg_rd_data_i,
    input  logic        reg_rd_done_i,
    output logic        start_test_o,
    output logic        rx_overrun_o
);

    state_e      state_q;
    logic [31:0] timer_q;
    logic [1:0]  byte_idx_q;
    logic        is_rd_q;
    logic [23:0] wr_shift_q;
    logic [7:0]  reg_addr_q;
    logic [31:0] reg_wr_data_q;
    logic        reg_wr_en_q;
    logic        reg_rd_en_q;
    logic        start_test_q;
    logic        rx_overrun_q;

    logic        snd_load;
    logic [31:0] snd_bytes;
    logic [2:0]  snd_count;
    logic        snd_done;
    logic        busy;

    assign busy = (state_q == ST_WR) || (state_q == ST_RD_REQ) || (state_q == ST_RD_WAIT) ||
                  (state_q == ST_START) || (state_q == ST_TX);

    // Responses load the sender on the same edge the FSM enters TX.
    always_comb begin
        snd_load  = 1'b0;
        snd_bytes = 32'h0;
        snd_count = 3'd1;
        case (state_q)
            ST_IDLE: begin
                if (rx_valid_i && rx_data_i != OP_WRITE && rx_data_i != OP_READ &&
                    rx_data_i != OP_START) begin
                    snd_load  = 1'b1;
                    snd_bytes = {24'h0, RSP_ERR};
                end
            end
            ST_WR: begin
                snd_load  = 1'b1;
                snd_bytes = {24'h0, RSP_OK};
            end
            ST_RD_REQ, ST_RD_WAIT: begin
                if (reg_rd_done_i) begin
                    snd_load  = 1'b1;
                    snd_bytes = reg_rd_data_i;
                    snd_count = 3'd4;
                end else if (state_q == ST_RD_WAIT && timer_q == 32'(RD_TIMEOUT)) begin
                    snd_load  = 1'b1;
                    snd_bytes = {24'h0, RSP_TMO};
                end
            end
            ST_START: begin
                if (timer_q == 32'(START_PULSE_CYCLES)) begin
                    snd_load  = 1'b1;
                    snd_bytes = {24'h0, RSP_OK};
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge core_clk_25Mhz or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            timer_q       <= 32'h0;
            byte_idx_q    <= 2'd0;
            is_rd_q       <= 1'b0;
            wr_shift_q    <= 24'h0;
            reg_addr_q    <= 8'h00;
            reg_wr_data_q <= 32'h0;
            reg_wr_en_q   <= 1'b0;
            reg_rd_en_q   <= 1'b0;
            start_test_q  <= 1'b0;
            rx_overrun_q  <= 1'b0;
        end else begin
            reg_wr_en_q <= 1'b0;
            reg_rd_en_q <= 1'b0;
            if (rx_valid_i && busy) begin
                rx_overrun_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (rx_valid_i) begin
                        timer_q <= 32'h0;
                        case (rx_data_i)
                            OP_WRITE: begin is_rd_q <= 1'b0; state_q <= ST_ADDR; end
                            OP_READ:  begin is_rd_q <= 1'b1; state_q <= ST_ADDR; end
                            OP_START: begin
                                start_test_q <= 1'b1;
                                timer_q      <= 32'h1;
                                state_q      <= ST_START;
                            end
                            default:  state_q <= ST_TX;
                        endcase
                    end
                end
                ST_ADDR: begin
                    if (rx_valid_i) begin
                        reg_addr_q <= rx_data_i;
                        timer_q    <= 32'h0;
                        byte_idx_q <= 2'd0;
                        if (is_rd_q) begin
                            reg_rd_en_q <= 1'b1;
                            state_q     <= ST_RD_REQ;
                        end else begin
                            state_q <= ST_DATA;
                        end
                    end else if (timer_q == 32'(BYTE_TIMEOUT)) begin
                        state_q <= ST_IDLE;
                    end else begin
                        timer_q <= timer_q + 32'h1;
                    end
                end
                ST_DATA: begin
                    if (rx_valid_i) begin
                        timer_q    <= 32'h0;
                        wr_shift_q <= {wr_shift_q[15:0], rx_data_i};
                        byte_idx_q <= byte_idx_q + 2'd1;
                        if (byte_idx_q == 2'd3) begin
                            reg_wr_data_q <= {wr_shift_q, rx_data_i};
                            reg_wr_en_q   <= 1'b1;
                            state_q       <= ST_WR;
                        end
                    end else if (timer_q == 32'(BYTE_TIMEOUT)) begin
                        state_q <= ST_IDLE;
                    end else begin
                        timer_q <= timer_q + 32'h1;
                    end
                end
                ST_WR: state_q <= ST_TX;
                ST_RD_REQ: begin
                    timer_q <= 32'h1;
                    state_q <= reg_rd_done_i ? ST_TX : ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    if (reg_rd_done_i || timer_q == 32'(RD_TIMEOUT)) begin
                        state_q <= ST_TX;
                    end else begin
                        timer_q <= timer_q + 32'h1;
                    end
                end
                ST_START: begin
                    if (timer_q == 32'(START_PULSE_CYCLES)) begin
                        start_test_q <= 1'b0;
                        state_q      <= ST_TX;
                    end else begin
                        timer_q <= timer_q + 32'h1;
                    end
                end
                ST_TX: begin
                    if (snd_done) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    dbg_resp_sender u_sender (
        .core_clk_25Mhz (core_clk_25Mhz),
        .rst_n          (rst_n),
        .load_i         (snd_load),
        .bytes_i        (snd_bytes),
        .count_i        (snd_count),
        .tx_ready_i     (tx_ready_i),
        .tx_data_o      (tx_data_o),
        .tx_valid_o     (tx_valid_o),
        .done_o         (snd_done)
    );

    assign reg_addr_o    = reg_addr_q;
    assign reg_wr_data_o = reg_wr_data_q;
    assign reg_wr_en_o   = reg_wr_en_q;
    assign reg_rd_en_o   = reg_rd_en_q;
    assign start_test_o  = start_test_q;
    assign rx_overrun_o  = rx_overrun_q;

endmodule

// File: tb/tb_uart_dbg_cmd_master.sv
// tb/tb_uart_dbg_cmd_master.sv - scoreboard bench for uart_dbg_cmd_master
module tb_uart_dbg_cmd_master;

    localparam int BYTE_TO = 64;
    localparam int RD_TO   = 16;
    localparam int PULSE   = 4;

    logic        core_clk_25Mhz = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic [7:0]  reg_addr;
    logic [31:0] reg_wr_data;
    logic        reg_wr_en;
    logic        reg_rd_en;
    logic [31:0] reg_rd_data = 32'h0;
    logic        reg_rd_done = 1'b0;
    logic        start_test;
    logic        rx_overrun;

    int tests = 0;
    int fails = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;
    int st_cnt = 0;
    int ready_mode = 0;  // 0: always ready, 1: toggle, 2: held low, 3: driven by the test
    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;

    uart_dbg_cmd_master #(
        .BYTE_TIMEOUT       (BYTE_TO),
        .RD_TIMEOUT         (RD_TO),
        .START_PULSE_CYCLES (PULSE)
    ) dut (
        .core_clk_25Mhz (core_clk_25Mhz),
        .rst_n          (rst_n),
        .rx_data_i      (rx_data),
        .rx_valid_i     (rx_valid),
        .tx_data_o      (tx_data),
        .tx_valid_o     (tx_valid),
        .tx_ready_i     (tx_ready),
        .reg_addr_o     (reg_addr),
        .reg_wr_data_o  (reg_wr_data),
        .reg_wr_en_o    (reg_wr_en),
        .reg_rd_en_o    (reg_rd_en),
        .reg_rd_data_i  (reg_rd_data),
        .reg_rd_done_i  (reg_rd_done),
        .start_test_o   (start_test),
        .rx_overrun_o   (rx_overrun)
    );

    always #20 core_clk_25Mhz = ~core_clk_25Mhz;

    initial begin
        forever begin
            @(posedge core_clk_25Mhz);
            #1;
            if (ready_mode == 0) tx_ready = 1'b1;
            else if (ready_mode == 1) tx_ready = ~tx_ready;
            else if (ready_mode == 2) tx_ready = 1'b0;
        end
    end

    // Scoreboard pop, stall stability and strobe counting, all sampled mid-cycle.
    always @(negedge core_clk_25Mhz) begin
        if (rst_n) begin
            if (prev_stall) begin
                tests++;
                if (tx_valid !== 1'b1 || tx_data !== prev_data) begin
                    fails++;
                    $display("FAIL tx_stable: valid=%b data=%h, required valid=1 data=%h",
                             tx_valid, tx_data, prev_data);
                end
            end
            if (tx_valid && tx_ready) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL tx_unexpected: got byte %h, required none", tx_data);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (tx_data !== mon_exp) begin
                        fails++;
                        $display("FAIL tx_byte: got %h, required %h", tx_data, mon_exp);
                    end
                end
            end
            if (reg_wr_en)  wr_cnt++;
            if (reg_rd_en)  rd_cnt++;
            if (start_test) st_cnt++;
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic step();
        @(posedge core_clk_25Mhz);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int k = 0; k < 300; k++) begin
            if (exp_q.size() == 0 && !tx_valid) break;
            step();
        end
        tests++;
        if (exp_q.size() != 0 || tx_valid !== 1'b0) begin
            fails++;
            $display("FAIL %s_drain: %0d bytes pending, tx_valid=%b, required 0 and 0",
                     name, exp_q.size(), tx_valid);
            exp_q.delete();
        end
    endtask

    task automatic check_reset_values(input string name);
        tests++;
        if ({tx_data, tx_valid, reg_addr, reg_wr_data, reg_wr_en, reg_rd_en, start_test,
             rx_overrun} !== 54'h0) begin
            fails++;
            $display("FAIL %s: tx=%h/%b addr=%h wd=%h we=%b re=%b st=%b ov=%b, required all 0",
                     name, tx_data, tx_valid, reg_addr, reg_wr_data, reg_wr_en, reg_rd_en,
                     start_test, rx_overrun);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        check_reset_values("reset_values");
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_write();
        int wr0;
        wr0 = wr_cnt;
        exp_q.push_back(8'h4B);
        send_byte(8'h57);
        send_byte(8'h05);
        send_byte(8'hDE);
        send_byte(8'hAD);
        send_byte(8'hBE);
        send_byte(8'hEF);
        tests++;
        if (reg_wr_en !== 1'b1 || reg_addr !== 8'h05 || reg_wr_data !== 32'hDEADBEEF ||
            tx_valid !== 1'b0) begin
            fails++;
            $display("FAIL write_strobe: we=%b addr=%h data=%h txv=%b, required 1 05 deadbeef 0",
                     reg_wr_en, reg_addr, reg_wr_data, tx_valid);
        end
        step();
        tests++;
        if (reg_wr_en !== 1'b0 || tx_valid !== 1'b1 || tx_data !== 8'h4B) begin
            fails++;
            $display("FAIL write_resp: we=%b txv=%b tx=%h, required 0 1 4b",
                     reg_wr_en, tx_valid, tx_data);
        end
        wait_idle("write");
        tests++;
        if (wr_cnt - wr0 != 1 || reg_wr_data !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL write_count: strobes=%0d data=%h, required 1 deadbeef",
                     wr_cnt - wr0, reg_wr_data);
        end
    endtask

    task automatic test_read(input logic [7:0] addr, input logic [31:0] data, input int mode);
        int rd0;
        rd0 = rd_cnt;
        ready_mode = mode;
        for (int i = 3; i >= 0; i--) exp_q.push_back(data[i*8 +: 8]);
        send_byte(8'h52);
        send_byte(addr);
        tests++;
        if (reg_rd_en !== 1'b1 || reg_addr !== addr) begin
            fails++;
            $display("FAIL read_strobe: re=%b addr=%h, required 1 %h", reg_rd_en, reg_addr, addr);
        end
        step();
        reg_rd_data = data;
        reg_rd_done = 1'b1;
        step();
        reg_rd_done = 1'b0;
        reg_rd_data = 32'h0;
        tests++;
        if (tx_valid !== 1'b1 || tx_data !== data[31:24]) begin
            fails++;
            $display("FAIL read_first_byte: txv=%b tx=%h, required 1 %h",
                     tx_valid, tx_data, data[31:24]);
        end
        wait_idle("read");
        ready_mode = 0;
        tests++;
        if (rd_cnt - rd0 != 1) begin
            fails++;
            $display("FAIL read_count: strobes=%0d, required 1", rd_cnt - rd0);
        end
    endtask

    task automatic test_start();
        int st0;
        st0 = st_cnt;
        exp_q.push_back(8'h4B);
        send_byte(8'h53);
        for (int i = 0; i < PULSE; i++) begin
            tests++;
            if (start_test !== 1'b1 || tx_valid !== 1'b0) begin
                fails++;
                $display("FAIL start_pulse[%0d]: st=%b txv=%b, required 1 0", i, start_test, tx_valid);
            end
            step();
        end
        tests++;
        if (start_test !== 1'b0 || tx_valid !== 1'b1 || tx_data !== 8'h4B) begin
            fails++;
            $display("FAIL start_resp: st=%b txv=%b tx=%h, required 0 1 4b",
                     start_test, tx_valid, tx_data);
        end
        wait_idle("start");
        tests++;
        if (st_cnt - st0 != PULSE) begin
            fails++;
            $display("FAIL start_len: %0d cycles, required %0d", st_cnt - st0, PULSE);
        end
    endtask

    task automatic test_unknown();
        int s0;
        s0 = wr_cnt + rd_cnt + st_cnt;
        exp_q.push_back(8'h3F);
        send_byte(8'hA0);
        tests++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h3F) begin
            fails++;
            $display("FAIL unknown_resp: txv=%b tx=%h, required 1 3f", tx_valid, tx_data);
        end
        wait_idle("unknown");
        tests++;
        if (wr_cnt + rd_cnt + st_cnt != s0) begin
            fails++;
            $display("FAIL unknown_strobes: %0d strobes, required 0", wr_cnt + rd_cnt + st_cnt - s0);
        end
    endtask

    task automatic test_byte_timeout();
        int wr0;
        int seen;
        wr0 = wr_cnt;
        seen = 0;
        send_byte(8'h57);
        send_byte(8'h05);
        send_byte(8'hDE);
        for (int i = 0; i < BYTE_TO + 5; i++) begin
            if (tx_valid) seen++;
            step();
        end
        tests++;
        if (seen != 0 || wr_cnt != wr0) begin
            fails++;
            $display("FAIL byte_timeout: tx cycles=%0d writes=%0d, required 0 0", seen, wr_cnt - wr0);
        end
        test_read(8'h05, 32'hCAFE0123, 0);
    endtask

    task automatic test_rd_timeout();
        int k;
        exp_q.push_back(8'h45);
        send_byte(8'h52);
        send_byte(8'h07);
        k = 0;
        while (!tx_valid && k < 100) begin
            step();
            k++;
        end
        tests++;
        if (k != RD_TO + 1 || tx_data !== 8'h45) begin
            fails++;
            $display("FAIL rd_timeout: rose after %0d cycles with %h, required %0d with 45",
                     k, tx_data, RD_TO + 1);
        end
        wait_idle("rd_timeout");
    endtask

    task automatic test_overrun();
        ready_mode = 2;
        step();
        exp_q.push_back(8'h3F);
        send_byte(8'hA0);
        tests++;
        if (rx_overrun !== 1'b0) begin
            fails++;
            $display("FAIL overrun_pre: ov=%b, required 0", rx_overrun);
        end
        send_byte(8'h57);
        tests++;
        if (rx_overrun !== 1'b1 || tx_valid !== 1'b1 || tx_data !== 8'h3F) begin
            fails++;
            $display("FAIL overrun_set: ov=%b txv=%b tx=%h, required 1 1 3f",
                     rx_overrun, tx_valid, tx_data);
        end
        ready_mode = 0;
        wait_idle("overrun");
    endtask

    task automatic test_reset_midframe();
        int wr0;
        wr0 = wr_cnt;
        send_byte(8'h57);
        send_byte(8'h05);
        send_byte(8'hDE);
        send_byte(8'hAD);
        rst_n = 1'b0;
        #1;
        check_reset_values("reset_midframe");
        step();
        step();
        rst_n = 1'b1;
        step();
        exp_q.push_back(8'h3F);
        send_byte(8'hBE);
        wait_idle("reset_bytes");
        exp_q.push_back(8'h3F);
        send_byte(8'hEF);
        wait_idle("reset_bytes2");
        tests++;
        if (wr_cnt != wr0) begin
            fails++;
            $display("FAIL reset_no_write: %0d writes, required 0", wr_cnt - wr0);
        end
    endtask

    task automatic test_back_to_back();
        ready_mode = 3;
        tx_ready = 1'b0;
        exp_q.push_back(8'h3F);
        send_byte(8'hA0);
        tx_ready = 1'b1;
        rx_data  = 8'h52;
        rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
        tests++;
        if (tx_valid !== 1'b0 || rx_overrun !== 1'b1) begin
            fails++;
            $display("FAIL final_hs_overrun: txv=%b ov=%b, required 0 1", tx_valid, rx_overrun);
        end
        exp_q.push_back(8'h3F);
        send_byte(8'hA0);
        tests++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h3F) begin
            fails++;
            $display("FAIL next_opcode: txv=%b tx=%h, required 1 3f", tx_valid, tx_data);
        end
        ready_mode = 0;
        wait_idle("back_to_back");
    endtask

    initial begin
        test_reset();
        test_write();
        test_read(8'h05, 32'h12345678, 0);
        test_read(8'h05, 32'h12345678, 1);
        test_start();
        test_unknown();
        test_byte_timeout();
        test_rd_timeout();
        test_overrun();
        test_reset_midframe();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
